ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 137 +++++++++++++
 tb/tb_ram_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a shared 2**ADDR_W x 1 bit array; one access per two cycles.
// Define RR_ARB_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module ram_arbiter #(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic              wdata0,
  input  logic              wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic              rdata0,
  output logic              rdata1
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic {
    StIdle,
    StAccess
  } state_e;

  state_e             r_state;
  state_e             w_state_d;
  logic               r_gnt0;
  logic               r_gnt1;
  logic               w_gnt0_d;
  logic               w_gnt1_d;
  logic               w_pick0;
  logic [Depth-1:0]   r_mem;
  logic               r_rvalid0;
  logic               r_rvalid1;
  logic               r_rdata0;
  logic               r_rdata1;
  logic               w_acc_we;
  logic [ADDR_W-1:0]  w_acc_addr;
  logic               w_acc_wdata;

`ifdef RR_ARB_EN
  // High when port 1 was granted most recently.
  logic r_last;

  always_comb begin
    w_pick0 = req0 && (!req1 || r_last);
  end
`else
  always_comb begin
    w_pick0 = req0;
  end
`endif

  always_comb begin
    w_state_d = r_state;
    w_gnt0_d  = 1'b0;
    w_gnt1_d  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (req0 || req1) begin
          w_state_d = StAccess;
          w_gnt0_d  = w_pick0;
          w_gnt1_d  = !w_pick0;
        end
      end
      StAccess: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
`ifdef RR_ARB_EN
      r_last  <= 1'b1;
`endif
    end else begin
      r_state <= w_state_d;
      r_gnt0  <= w_gnt0_d;
      r_gnt1  <= w_gnt1_d;
`ifdef RR_ARB_EN
      if (w_gnt0_d || w_gnt1_d) begin
        r_last <= w_gnt1_d;
      end
`endif
    end
  end

  // Requesters hold their controls until gnt is seen, so the live inputs are used in ACCESS.
  always_comb begin
    w_acc_we    = r_gnt1 ? we1    : we0;
    w_acc_addr  = r_gnt1 ? addr1  : addr0;
    w_acc_wdata = r_gnt1 ? wdata1 : wdata0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_mem     <= '0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= 1'b0;
      r_rdata1  <= 1'b0;
    end else begin
      if ((r_gnt0 || r_gnt1) && w_acc_we) begin
        r_mem[w_acc_addr] <= w_acc_wdata;
      end
      r_rvalid0 <= r_gnt0 && !we0;
      r_rvalid1 <= r_gnt1 && !we1;
      if (r_gnt0 && !we0) begin
        r_rdata0 <= r_mem[addr0];
      end
      if (r_gnt1 && !we1) begin
        r_rdata1 <= r_mem[addr1];
      end
    end
  end

  assign gnt0    = r_gnt0;
  assign gnt1    = r_gnt1;
  assign rvalid0 = r_rvalid0;
  assign rvalid1 = r_rvalid1;
  assign rdata0  = r_rdata0;
  assign rdata1  = r_rdata1;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: stimulus pushes expected grants/reads, a monitor pops them.
module tb_ram_arbiter;

  localparam int unsigned AW = 4;

  logic          clock   = 1'b0;
  logic          reset_n = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic          we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic          wdata0 = 1'b0, wdata1 = 1'b0;
  logic          gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1;

  int checks     = 0;
  int failures   = 0;
  int gnt_seen   = 0;
  int exp_gnt_q[$];
  logic [1:0] exp_rd_q[$];

  ram_arbiter #(.ADDR_W(AW)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .req0   (req0),
    .req1   (req1),
    .we0    (we0),
    .we1    (we1),
    .addr0  (addr0),
    .addr1  (addr1),
    .wdata0 (wdata0),
    .wdata1 (wdata1),
    .gnt0   (gnt0),
    .gnt1   (gnt1),
    .rvalid0(rvalid0),
    .rvalid1(rvalid1),
    .rdata0 (rdata0),
    .rdata1 (rdata1)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a grant or read data.
  initial begin
    int e;
    logic [1:0] er;
    logic [1:0] ar;
    forever begin
      @(negedge clock);
      check("mutex", int'((gnt0 && gnt1) || (rvalid0 && rvalid1)), 0);
      if (gnt0 || gnt1) begin
        gnt_seen++;
        if (exp_gnt_q.size() == 0) begin
          check("unexpected_grant", int'(gnt1), -1);
        end else begin
          e = exp_gnt_q.pop_front();
          check("grant_port", int'(gnt1), e);
        end
      end
      if (rvalid0 || rvalid1) begin
        ar = {rvalid1, rvalid1 ? rdata1 : rdata0};
        if (exp_rd_q.size() == 0) begin
          check("unexpected_rvalid", int'(ar), -1);
        end else begin
          er = exp_rd_q.pop_front();
          check("read_port_data", int'(ar), int'(er));
        end
      end
    end
  end

  task automatic drive(input int port, input logic req, input logic we, input logic [AW-1:0] a,
                       input logic wd);
    if (port == 0) begin
      req0 = req; we0 = we; addr0 = a; wdata0 = wd;
    end else begin
      req1 = req; we1 = we; addr1 = a; wdata1 = wd;
    end
  endtask

  task automatic push_exp(input int port, input logic we, input logic exp_rd);
    logic [1:0] tmp;
    exp_gnt_q.push_back(port);
    if (!we) begin
      tmp = {port == 1, exp_rd};
      exp_rd_q.push_back(tmp);
    end
  endtask

  task automatic wait_gnt(input int port);
    bit got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clock);
      got = (port == 0) ? gnt0 : gnt1;
    end
    check("grant_timeout", int'(got), 1);
  endtask

  task automatic access(input int port, input logic we, input logic [AW-1:0] a, input logic wd,
                        input logic exp_rd);
    push_exp(port, we, exp_rd);
    drive(port, 1'b1, we, a, wd);
    wait_gnt(port);
    @(posedge clock);
    #1;
    drive(port, 1'b0, we, a, wd);
  endtask

  task automatic drain();
    repeat (3) @(posedge clock);
    #1;
  endtask

  initial begin
    int g0;
    #12;
    check("rst_gnt0", int'(gnt0), 0);
    check("rst_gnt1", int'(gnt1), 0);
    check("rst_rvalid0", int'(rvalid0), 0);
    check("rst_rvalid1", int'(rvalid1), 0);
    check("rst_rdata0", int'(rdata0), 0);
    check("rst_rdata1", int'(rdata1), 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Write then read-back on port 0.
    access(0, 1'b1, 4'd3, 1'b1, 1'b0);
    access(0, 1'b0, 4'd3, 1'b0, 1'b1);
    drain();

    // Cross-port visibility and an untouched cell.
    access(1, 1'b1, 4'd5, 1'b1, 1'b0);
    access(0, 1'b0, 4'd5, 1'b0, 1'b1);
    access(0, 1'b0, 4'd6, 1'b0, 1'b0);
    access(1, 1'b0, 4'd5, 1'b0, 1'b1);
    drain();

    // Both ports requesting for 8 edges; port 1 was granted last.
`ifdef RR_ARB_EN
    push_exp(0, 1'b0, 1'b1);
    push_exp(1, 1'b0, 1'b1);
    push_exp(0, 1'b0, 1'b1);
    push_exp(1, 1'b0, 1'b1);
`else
    repeat (4) push_exp(0, 1'b0, 1'b1);
`endif
    g0 = gnt_seen;
    drive(0, 1'b1, 1'b0, 4'd3, 1'b0);
    drive(1, 1'b1, 1'b0, 4'd5, 1'b0);
    repeat (8) @(posedge clock);
    #1;
    req0 = 1'b0;
    req1 = 1'b0;
    drain();
    check("contention_grant_count", gnt_seen - g0, 4);

    // Reset during the ACCESS cycle of a write must abort it.
    push_exp(0, 1'b1, 1'b0);
    drive(0, 1'b1, 1'b1, 4'd2, 1'b1);
    wait_gnt(0);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_gnt0", int'(gnt0), 0);
    check("abort_gnt1", int'(gnt1), 0);
    check("abort_rvalid0", int'(rvalid0), 0);
    req0 = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    access(0, 1'b0, 4'd2, 1'b0, 1'b0);
    drain();

    // Fill with ones, read both ends from port 1.
    for (int a = 0; a < 2 ** AW; a++) begin
      access(0, 1'b1, AW'(a), 1'b1, 1'b0);
    end
    access(1, 1'b0, 4'd0, 1'b0, 1'b1);
    access(1, 1'b0, 4'd15, 1'b0, 1'b1);
    drain();

    check("grant_queue_empty", exp_gnt_q.size(), 0);
    check("read_queue_empty", exp_rd_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
